// File: rtl/alu_regfile_seq.sv
// alu_regfile_seq: NREGS x WIDTH register file with a sequenced 8-op ALU.
//
// A controller issues register-to-register ops with a start/busy/done
// handshake. An external port preloads or overwrites registers while the
// block is idle. Result and flags are registered and hold between ops.
//
// Optional feature macro: ALUREG_MUL_EN
//   defined   : op 7 is a multi-cycle shift-add unsigned multiply (WIDTH steps)
//   undefined : op 7 is MOV (result = B), single-cycle like the other ops
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   start     issue op (sampled only while idle)
//   op        0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL/MOV
//   src_a     operand A register index
//   src_b     operand B register index
//   dst       destination register index
//   ext_wr    external register write enable (honoured only while idle)
//   ext_addr  external write address
//   ext_data  external write data
//   rd_addr   debug read address
//   rd_data   R[rd_addr], combinational
//   busy      op in flight
//   done      one-cycle pulse during write-back
//   result    last written ALU result
//   cout      carry / overflow flag
//   zero      result == 0 flag
//   neg       result MSB flag
module alu_regfile_seq #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    src_a,
  input  logic [AW-1:0]    src_b,
  input  logic [AW-1:0]    dst,
  input  logic             ext_wr,
  input  logic [AW-1:0]    ext_addr,
  input  logic [WIDTH-1:0] ext_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             neg
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH[WIDTH-1:0];

`ifdef ALUREG_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    WB   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd3
  } state_t;
`endif

  state_t           state_r;
  state_t           state_next_s;
  logic             busy_r;
  logic             done_r;

  logic [WIDTH-1:0] regs_r [NREGS];
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       op_r;
  logic [AW-1:0]    dst_r;

  logic [WIDTH-1:0] alu_res_s;
  logic             alu_cout_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] shamt_s;
  logic [WIDTH-1:0] alu_res_r;
  logic             alu_cout_r;

  logic [WIDTH-1:0] wb_res_s;
  logic             wb_cout_s;

  logic [WIDTH-1:0] result_r;
  logic             cout_r;
  logic             zero_r;
  logic             neg_r;

`ifdef ALUREG_MUL_EN
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      cnt_r;
`endif

  // Next-state decode for the op sequencer
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = EXEC;
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: begin
`ifdef ALUREG_MUL_EN
        if (op_r == OP_MUL) begin
          state_next_s = MUL;
        end else begin
          state_next_s = WB;
        end
`else
        state_next_s = WB;
`endif
      end
`ifdef ALUREG_MUL_EN
      MUL: begin
        // Last step happens on the edge that sees the counter at one
        if (cnt_r == CNT_ONE) begin
          state_next_s = WB;
        end else begin
          state_next_s = MUL;
        end
      end
`endif
      WB:      state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register; busy/done are registered from the next state so they
  // line up exactly with the state they describe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
      done_r  <= (state_next_s == WB);
    end
  end

  // Single-cycle ALU on the latched operands
  always_comb begin
    alu_res_s  = '0;
    alu_cout_s = 1'b0;
    sum_s      = '0;
    shamt_s    = b_r % WIDTH_V;
    case (op_r)
      OP_ADD: begin
        sum_s      = {1'b0, a_r} + {1'b0, b_r};
        alu_res_s  = sum_s[WIDTH-1:0];
        alu_cout_s = sum_s[WIDTH];
      end
      OP_SUB: begin
        // Carry out of A + ~B + 1: set means no borrow
        sum_s      = {1'b0, a_r} + {1'b0, ~b_r} + {{WIDTH{1'b0}}, 1'b1};
        alu_res_s  = sum_s[WIDTH-1:0];
        alu_cout_s = sum_s[WIDTH];
      end
      OP_AND:  alu_res_s = a_r & b_r;
      OP_OR:   alu_res_s = a_r | b_r;
      OP_XOR:  alu_res_s = a_r ^ b_r;
      OP_SHL:  alu_res_s = a_r << shamt_s;
      OP_SHR:  alu_res_s = a_r >> shamt_s;
`ifdef ALUREG_MUL_EN
      // Product comes from the accumulator, not from this path
      OP_MUL:  alu_res_s = '0;
`else
      OP_MUL:  alu_res_s = b_r;
`endif
      default: alu_res_s = '0;
    endcase
  end

  // Select the value committed at write-back
  always_comb begin
    wb_res_s  = alu_res_r;
    wb_cout_s = alu_cout_r;
`ifdef ALUREG_MUL_EN
    if (op_r == OP_MUL) begin
      wb_res_s  = acc_r[WIDTH-1:0];
      wb_cout_s = |acc_r[2*WIDTH-1:WIDTH];
    end else begin
      wb_res_s  = alu_res_r;
      wb_cout_s = alu_cout_r;
    end
`endif
  end

  // Register file, operand latches, multiplier and result/flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
      a_r        <= '0;
      b_r        <= '0;
      op_r       <= 3'd0;
      dst_r      <= '0;
      alu_res_r  <= '0;
      alu_cout_r <= 1'b0;
      result_r   <= '0;
      cout_r     <= 1'b0;
      zero_r     <= 1'b0;
      neg_r      <= 1'b0;
`ifdef ALUREG_MUL_EN
      acc_r      <= '0;
      mcand_r    <= '0;
      mplier_r   <= '0;
      cnt_r      <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          // Non-blocking reads give the pre-write operands when ext_wr
          // and start share the same edge
          if (ext_wr) begin
            regs_r[ext_addr] <= ext_data;
          end
          if (start) begin
            a_r   <= regs_r[src_a];
            b_r   <= regs_r[src_b];
            op_r  <= op;
            dst_r <= dst;
          end
        end
        EXEC: begin
          alu_res_r  <= alu_res_s;
          alu_cout_r <= alu_cout_s;
`ifdef ALUREG_MUL_EN
          acc_r    <= '0;
          mcand_r  <= {{WIDTH{1'b0}}, a_r};
          mplier_r <= b_r;
          cnt_r    <= CNT_INIT;
`endif
        end
`ifdef ALUREG_MUL_EN
        MUL: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r - CNT_ONE;
        end
`endif
        WB: begin
          regs_r[dst_r] <= wb_res_s;
          result_r      <= wb_res_s;
          cout_r        <= wb_cout_s;
          zero_r        <= (wb_res_s == '0);
          neg_r         <= wb_res_s[WIDTH-1];
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

  assign rd_data = regs_r[rd_addr];
  assign busy    = busy_r;
  assign done    = done_r;
  assign result  = result_r;
  assign cout    = cout_r;
  assign zero    = zero_r;
  assign neg     = neg_r;

endmodule

// File: tb/tb_alu_regfile_seq.sv
// Directed testbench for alu_regfile_seq (WIDTH=16, NREGS=8).
// Stimulus pushes the expected write-back into a queue; a monitor pops it
// whenever done is seen and checks result, flags and the destination register.
module tb_alu_regfile_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [2:0]  src_a;
  logic [2:0]  src_b;
  logic [2:0]  dst;
  logic        ext_wr;
  logic [2:0]  ext_addr;
  logic [15:0] ext_data;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        zero;
  logic        neg;

  logic [2:0]  stim_sel;
  logic [2:0]  mon_sel;
  logic        mon_active;

  assign rd_addr = mon_active ? mon_sel : stim_sel;

  typedef struct {
    logic [2:0]  d;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        n;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

`ifdef ALUREG_MUL_EN
  localparam int ABORT_WAIT = 4;
`else
  localparam int ABORT_WAIT = 0;
`endif

  alu_regfile_seq #(.WIDTH(16), .NREGS(8), .AW(3)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .dst(dst),
    .ext_wr(ext_wr), .ext_addr(ext_addr), .ext_data(ext_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .result(result),
    .cout(cout), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, expv);
    end
  endtask

  task automatic rchk(input string nm, input logic [2:0] a, input logic [15:0] expv);
    stim_sel = a;
    #1;
    chk(nm, {16'd0, rd_data}, {16'd0, expv});
  endtask

  task automatic ext(input logic [2:0] a, input logic [15:0] dta);
    @(negedge clk);
    ext_wr   = 1'b1;
    ext_addr = a;
    ext_data = dta;
    @(posedge clk);
    #1;
    ext_wr = 1'b0;
  endtask

  // Issue one op; poke>0 drives a competing start and ext_wr to R5 while busy
  task automatic issue(input logic [2:0] o, input logic [2:0] sa, input logic [2:0] sb,
                       input logic [2:0] d, input logic [15:0] r, input logic c,
                       input logic z, input logic n, input int elat, input int poke,
                       input logic wext, input logic [2:0] ea, input logic [15:0] ed);
    int   lat;
    logic bok;
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    op       = o;
    src_a    = sa;
    src_b    = sb;
    dst      = d;
    ext_wr   = wext;
    ext_addr = ea;
    ext_data = ed;
    e.d = d; e.res = r; e.c = c; e.z = z; e.n = n;
    q.push_back(e);
    @(posedge clk);
    #1;
    start  = 1'b0;
    ext_wr = 1'b0;
    lat = 1;
    bok = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == poke) begin
        start    = 1'b1;
        op       = 3'd0;
        src_a    = 3'd0;
        src_b    = 3'd0;
        dst      = 3'd5;
        ext_wr   = 1'b1;
        ext_addr = 3'd5;
        ext_data = 16'hAAAA;
      end else begin
        start  = 1'b0;
        ext_wr = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (busy !== 1'b1) bok = 1'b0;
    end
    start  = 1'b0;
    ext_wr = 1'b0;
    chk($sformatf("latency_op%0d", o), lat, elat);
    chk($sformatf("busy_held_op%0d", o), {31'd0, bok}, 32'd1);
    @(posedge clk);
    #1;
    chk("busy_after_wb", {31'd0, busy}, 32'd0);
    chk("done_after_wb", {31'd0, done}, 32'd0);
  endtask

  // Scoreboard monitor: on each done pulse, check the write-back after its edge
  initial begin
    exp_t e;
    mon_active = 1'b0;
    mon_sel    = 3'd0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          e = q.pop_front();
          mon_sel    = e.d;
          mon_active = 1'b1;
          @(posedge clk);
          #1;
          chk($sformatf("result_r%0d", e.d), {16'd0, result}, {16'd0, e.res});
          chk("cout", {31'd0, cout}, {31'd0, e.c});
          chk("zero", {31'd0, zero}, {31'd0, e.z});
          chk("neg", {31'd0, neg}, {31'd0, e.n});
          chk($sformatf("reg_r%0d", e.d), {16'd0, rd_data}, {16'd0, e.res});
          mon_active = 1'b0;
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; src_a = 3'd0; src_b = 3'd0; dst = 3'd0;
    ext_wr = 1'b0; ext_addr = 3'd0; ext_data = 16'd0; stim_sel = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_flags", {29'd0, cout, zero, neg}, 32'd0);
    for (int i = 0; i < 8; i++) rchk($sformatf("rst_r%0d", i), i[2:0], 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // ADD / SUB / carry wrap
    ext(3'd1, 16'h0003); ext(3'd2, 16'h0005);
    issue(3'd0, 3'd1, 3'd2, 3'd3, 16'h0008, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0, 3'd0, 16'h0);
    issue(3'd1, 3'd1, 3'd2, 3'd4, 16'hFFFE, 1'b0, 1'b0, 1'b1, 2, 0, 1'b0, 3'd0, 16'h0);
    ext(3'd1, 16'hFFFF); ext(3'd2, 16'h0001);
    issue(3'd0, 3'd1, 3'd2, 3'd3, 16'h0000, 1'b1, 1'b1, 1'b0, 2, 0, 1'b0, 3'd0, 16'h0);

    // Logic and shifts (shift amount 0x0FF4 mod 16 = 4)
    ext(3'd1, 16'hF0F0); ext(3'd2, 16'h0FF4);
    issue(3'd2, 3'd1, 3'd2, 3'd3, 16'h00F0, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0, 3'd0, 16'h0);
    issue(3'd3, 3'd1, 3'd2, 3'd3, 16'hFFF4, 1'b0, 1'b0, 1'b1, 2, 0, 1'b0, 3'd0, 16'h0);
    issue(3'd4, 3'd1, 3'd2, 3'd4, 16'hFF04, 1'b0, 1'b0, 1'b1, 2, 0, 1'b0, 3'd0, 16'h0);
    issue(3'd5, 3'd1, 3'd2, 3'd6, 16'h0F00, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0, 3'd0, 16'h0);
    issue(3'd6, 3'd1, 3'd2, 3'd7, 16'h0F0F, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0, 3'd0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("result_hold", {16'd0, result}, 32'h0000_0F0F);

    // Op 7, with competing start/ext_wr while busy
`ifdef ALUREG_MUL_EN
    ext(3'd1, 16'h0100); ext(3'd2, 16'h0100);
    issue(3'd7, 3'd1, 3'd2, 3'd5, 16'h0000, 1'b1, 1'b1, 1'b0, 18, 0, 1'b0, 3'd0, 16'h0);
    ext(3'd1, 16'h0007); ext(3'd2, 16'h0009);
    issue(3'd7, 3'd1, 3'd2, 3'd5, 16'h003F, 1'b0, 1'b0, 1'b0, 18, 5, 1'b0, 3'd0, 16'h0);
`else
    ext(3'd1, 16'h0007); ext(3'd2, 16'h0009);
    issue(3'd7, 3'd1, 3'd2, 3'd5, 16'h0009, 1'b0, 1'b0, 1'b0, 2, 1, 1'b0, 3'd0, 16'h0);
`endif

    // Same-cycle ext write and start: op sees the old R1
    ext(3'd1, 16'h0021);
    issue(3'd0, 3'd1, 3'd1, 3'd6, 16'h0042, 1'b0, 1'b0, 1'b0, 2, 0, 1'b1, 3'd1, 16'h0010);
    rchk("r1_after_ext", 3'd1, 16'h0010);

    // Reset in the middle of an op
    @(negedge clk);
    start = 1'b1; op = 3'd7; src_a = 3'd1; src_b = 3'd2; dst = 3'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (ABORT_WAIT) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", {16'd0, result}, 32'd0);
    rchk("abort_r1", 3'd1, 16'h0000);
    rchk("abort_r6", 3'd6, 16'h0000);
    rchk("abort_r7", 3'd7, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    ext(3'd1, 16'h0002); ext(3'd2, 16'h0003);
    issue(3'd0, 3'd1, 3'd2, 3'd7, 16'h0005, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0, 3'd0, 16'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_regfile_seq.md
Name: alu_regfile_seq

Overview:
- Parametrised successor to the 16-bit ALU/register-file datapath.
- NREGS x WIDTH register file, sequenced 8-op ALU with start/busy/done handshake, registered flags and a multi-cycle shift-add multiplier.
- A controller issues register-to-register ops. An external port preloads or overwrites registers while the block is idle.
- Sits between the control FSM and the rest of the datapath.

Parameters:
- WIDTH, 16: datapath and register width (>=4).
- NREGS, 8: number of registers (power of 2, >=2).
- AW, 3: register address width, equal to log2(NREGS).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  issue op; sampled only when busy=0.
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
- src_a  in  AW  operand A register index.
- src_b  in  AW  operand B register index.
- dst  in  AW  destination register index.
- ext_wr  in  1  external register write enable.
- ext_addr  in  AW  external write address.
- ext_data  in  WIDTH  external write data.
- rd_addr  in  AW  debug read address.
- rd_data  out  WIDTH  R[rd_addr], combinational.
- busy  out  1  op in flight.
- done  out  1  one-cycle pulse during write-back.
- result  out  WIDTH  last written ALU result, registered.
- cout  out  1  carry/overflow flag, registered.
- zero  out  1  result==0 flag, registered.
- neg  out  1  result MSB flag, registered.

Behaviour:
- Reset (async, reset=1):
  - All registers, result and flags go to 0.
  - state=IDLE, busy=0, done=0.
  - Reset mid-op aborts the op; no write-back occurs.
- States: IDLE, EXEC, MUL, WB.
- busy=1 in EXEC, MUL and WB. done=1 only in WB.
- IDLE:
  - start=1 at an edge latches A=R[src_a], B=R[src_b], op and dst, then goes to EXEC.
  - Operands are read before any same-edge write.
- EXEC:
  - op!=MUL: compute the result, then go to WB.
  - op==MUL: clear the accumulator, load the counter with WIDTH, then go to MUL.
- MUL (one shift-add step per cycle):
  - If multiplier bit 0 is set, add the shifted multiplicand into the 2*WIDTH accumulator.
  - Leave after WIDTH cycles and go to WB.
- WB:
  - On the edge ending WB: R[dst]<=result, result/flags update, state goes to IDLE.
  - R0 is an ordinary writable register.
- Latency, counted in edges after the edge that samples start:
  - ALU ops: done is high after edge 2 (until edge 3); new value readable after edge 3.
  - MUL: done is high after edge WIDTH+2.
  - busy falls with done at the next edge.
- Back-to-back: start may be asserted in the first IDLE cycle after WB.
- Arithmetic (all results truncated to WIDTH bits):
  - ADD: A+B; cout=carry out.
  - SUB: A+~B+1; cout=carry out (1 means no borrow).
  - AND, OR, XOR: cout=0.
  - SHL/SHR: shift A by B mod WIDTH, logical; cout=0.
  - MUL: result = low WIDTH bits of A*B (unsigned); cout=1 iff the upper WIDTH bits are nonzero.
  - zero = (result==0); neg = result[WIDTH-1].
- External write:
  - ext_wr is honoured only when busy=0 (R[ext_addr]<=ext_data) and is ignored while busy.
  - ext_wr and start in the same IDLE cycle: the ext write lands; the op uses the pre-write values.
- start while busy=1 is ignored; it is not queued.
- Flags and result hold their values between ops.

Optional Feature:
- Macro: ALUREG_MUL_EN.
- Defined: op 7 is the multi-cycle MUL described above.
- Undefined: no multiplier, no MUL state or counter. Op 7 becomes MOV: result=B, cout=0, with single-cycle latency like the other ALU ops.

Test Plan:
- ADD: ext-load R1=0x0003, R2=0x0005; ADD src_a=1 src_b=2 dst=3 -> done after edge 2, R3=0x0008, cout=0, zero=0, neg=0.
- SUB/ADD flags:
  - SUB R1-R2 into R4 -> R4=0xFFFE, cout=0, neg=1.
  - ADD 0xFFFF+0x0001 -> 0x0000, cout=1, zero=1.
- MUL: R1=0x0100, R2=0x0100 -> done after edge 18 (WIDTH=16), R5=0x0000, cout=1, zero=1.
  - Also R1=0x0007, R2=0x0009 -> 0x003F, cout=0.
  - Without ALUREG_MUL_EN: op 7 gives R5=B after 2 edges.
- Ignored inputs while busy:
  - During MUL, pulse start and ext_wr to R5=0xAAAA -> both ignored.
  - Only the MUL result reaches R5; busy stays high throughout.
- Same-cycle ext write + start: in IDLE, ext_wr R1=0x0010 together with start ADD R1+R1 into R6 -> R6 = 2*(old R1), then R1=0x0010.
- Reset mid-op:
  - Assert reset in MUL cycle 5 -> busy=0, done=0 immediately, all regs=0, no write-back.
  - After release, an ADD completes normally.
